// File: rtl/mult_f32_pipe.sv
// rtl/mult_f32_pipe.sv - binary32 floating-point multiplier with one registered output stage
//
// Purpose:
//   Multiplies two IEEE-754 single-precision operands, rounding to nearest
//   with ties to even. Subnormal inputs are treated as zero and results that
//   would be subnormal are flushed to zero. When infinity meets zero the
//   result is infinity. Every NaN result is the canonical quiet NaN 7FC00000.
//   The datapath is combinational up to a single output register, so the
//   product appears one cycle after its operands and a new pair can be
//   accepted every cycle.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset (clears m and out_valid)
//   in_valid  in   1   a/b hold an operand pair this cycle
//   a, b      in  32   binary32 operands
//   out_valid out  1   m holds the product of the pair accepted on the previous edge
//   m         out 32   binary32 product (held while no new pair is accepted)

module mult_f32_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] m
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic        sa, sb, sr;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic [47:0] prod;
  logic        norm;
  logic [22:0] frac_t;
  logic        guard, rnd, sticky, round_up;
  logic [24:0] sig_r;
  logic [22:0] frac_r;
  logic signed [9:0] exp_pre;
  logic signed [9:0] exp_fin;

  logic [31:0] result;

  // Field decode and operand classification
  always_comb begin
    sa = a[31];
    sb = b[31];
    ea = a[30:23];
    eb = b[30:23];
    fa = a[22:0];
    fb = b[22:0];
    sr = sa ^ sb;

    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'h0);
    b_inf  = (eb == 8'hFF) && (fb == 23'h0);
    a_nan  = (ea == 8'hFF) && (fa != 23'h0);
    b_nan  = (eb == 8'hFF) && (fb != 23'h0);
  end

  // Normal path: significand product, normalisation, RNE rounding
  always_comb begin
    prod = {24'h0, 1'b1, fa} * {24'h0, 1'b1, fb};
    norm = prod[47];

    // The product of two [1,2) significands lies in [1,4); bit 47 marks [2,4).
    if (norm) begin
      frac_t = prod[46:24];
      guard  = prod[23];
      rnd    = prod[22];
      sticky = |prod[21:0];
    end else begin
      frac_t = prod[45:23];
      guard  = prod[22];
      rnd    = prod[21];
      sticky = |prod[20:0];
    end

    // Ties (guard set, nothing below) go up only when the kept LSB is odd.
    round_up = guard & (rnd | sticky | frac_t[0]);

    sig_r = {1'b0, 1'b1, frac_t} + {24'h0, round_up};

    // A carry out of rounding leaves the significand at exactly 2.0, so the
    // renormalised fraction is all zeros.
    frac_r = sig_r[24] ? sig_r[23:1] : sig_r[22:0];

    exp_pre = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
              + $signed({9'h0, norm});
    exp_fin = exp_pre + $signed({9'h0, sig_r[24]});
  end

  // Special-value priority: NaN, then infinity, then zero, then the normal path.
  always_comb begin
    if (a_nan || b_nan) begin
      result = QNAN;
    end else if (a_inf || b_inf) begin
      result = {sr, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      result = {sr, 31'h0};
    end else if (exp_fin >= 10'sd255) begin
      result = {sr, 8'hFF, 23'h0};
    end else if (exp_fin <= 10'sd0) begin
      result = {sr, 31'h0};
    end else begin
      result = {sr, exp_fin[7:0], frac_r};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m         <= 32'h0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        m <= result;
      end
    end
  end

endmodule

// File: tb/tb_mult_f32_pipe.sv
// tb/tb_mult_f32_pipe.sv - directed self-checking bench for mult_f32_pipe

module tb_mult_f32_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] m;

  int n_vec;
  int n_err;

  mult_f32_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .m         (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y);
    in_valid = v;
    a        = x;
    b        = y;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h40200000, 32'h40400000);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (m !== 32'h00000000 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold%0d: m=%h out_valid=%b, want m=00000000 out_valid=0", i, m, out_valid);
      end
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (m !== 32'h40F00000 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: m=%h out_valid=%b, want m=40F00000 out_valid=1", m, out_valid);
    end
    // Reset on the same edge that would capture a pair discards it.
    drive(1'b1, 32'h3F800000, 32'h40000000);
    rst = 1'b1;
    tick();
    n_vec++;
    if (m !== 32'h00000000 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midop: m=%h out_valid=%b, want m=00000000 out_valid=0", m, out_valid);
    end
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  // Streams a table of pairs one per cycle; each result checked one edge later.
  task automatic run_stream(input string tag, input int n,
                            input logic [31:0] va [12], input logic [31:0] vb [12],
                            input logic [31:0] ve [12]);
    drive(1'b1, va[0], vb[0]);
    for (int i = 0; i < n; i++) begin
      tick();
      n_vec++;
      if (m !== ve[i] || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL %s[%0d] %h*%h: m=%h out_valid=%b, want m=%h out_valid=1",
                 tag, i, va[i], vb[i], m, out_valid, ve[i]);
      end
      if (i + 1 < n) drive(1'b1, va[i+1], vb[i+1]);
      else           drive(1'b0, 32'h0, 32'h0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [12];
    logic [31:0] vb [12];
    logic [31:0] ve [12];
    va = '{default: 32'h0};
    vb = '{default: 32'h0};
    ve = '{default: 32'h0};
    va[0] = 32'h40200000; vb[0] = 32'h40400000; ve[0] = 32'h40F00000;
    va[1] = 32'hBF8CCCCD; vb[1] = 32'h40A00000; ve[1] = 32'hC0B00000;
    va[2] = 32'h3F800000; vb[2] = 32'h3F800000; ve[2] = 32'h3F800000;
    run_stream("normal", 3, va, vb, ve);
  endtask

  task automatic test_zero_inf();
    logic [31:0] va [12];
    logic [31:0] vb [12];
    logic [31:0] ve [12];
    va = '{default: 32'h0};
    vb = '{default: 32'h0};
    ve = '{default: 32'h0};
    va[0] = 32'h40400000; vb[0] = 32'h00000000; ve[0] = 32'h00000000;
    va[1] = 32'h7F800000; vb[1] = 32'h00000000; ve[1] = 32'h7F800000;
    va[2] = 32'h00000000; vb[2] = 32'h7F800000; ve[2] = 32'h7F800000;
    va[3] = 32'hBF800000; vb[3] = 32'h7F800000; ve[3] = 32'hFF800000;
    va[4] = 32'h3F800000; vb[4] = 32'hFF800000; ve[4] = 32'hFF800000;
    va[5] = 32'hBF800000; vb[5] = 32'hFF800000; ve[5] = 32'h7F800000;
    va[6] = 32'hC0400000; vb[6] = 32'h00000000; ve[6] = 32'h80000000;
    run_stream("zero_inf", 7, va, vb, ve);
  endtask

  task automatic test_ovf_unf_nan();
    logic [31:0] va [12];
    logic [31:0] vb [12];
    logic [31:0] ve [12];
    va = '{default: 32'h0};
    vb = '{default: 32'h0};
    ve = '{default: 32'h0};
    va[0] = 32'h7F000000; vb[0] = 32'h40000000; ve[0] = 32'h7F800000;
    va[1] = 32'h00800000; vb[1] = 32'h00800000; ve[1] = 32'h00000000;
    va[2] = 32'h7FC00001; vb[2] = 32'h3F800000; ve[2] = 32'h7FC00000;
    va[3] = 32'hFF800001; vb[3] = 32'h00000000; ve[3] = 32'h7FC00000;
    va[4] = 32'h00000001; vb[4] = 32'h3F800000; ve[4] = 32'h00000000;
    run_stream("ovf_unf_nan", 5, va, vb, ve);
  endtask

  // Expected values hand-computed from the exact integer significand products.
  task automatic test_rounding();
    logic [31:0] va [12];
    logic [31:0] vb [12];
    logic [31:0] ve [12];
    va = '{default: 32'h0};
    vb = '{default: 32'h0};
    ve = '{default: 32'h0};
    va[0] = 32'h3F4F245A; vb[0] = 32'h3F34C34A; ve[0] = 32'h3F124394;
    va[1] = 32'h49742400; vb[1] = 32'h4CEAD734; ve[1] = 32'h56DFF624;
    run_stream("rounding", 2, va, vb, ve);
  endtask

  task automatic test_valid_gating();
    drive(1'b1, 32'h40200000, 32'h40400000);
    tick();
    n_vec++;
    if (m !== 32'h40F00000 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL gate_pre: m=%h out_valid=%b, want m=40F00000 out_valid=1", m, out_valid);
    end
    drive(1'b0, 32'h3F800000, 32'h40000000);
    tick();
    n_vec++;
    if (m !== 32'h40F00000 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL gate_drop: m=%h out_valid=%b, want m=40F00000 out_valid=0", m, out_valid);
    end
    drive(1'b1, 32'hBF8CCCCD, 32'h40A00000);
    tick();
    n_vec++;
    if (m !== 32'hC0B00000 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL gate_resume: m=%h out_valid=%b, want m=C0B00000 out_valid=1", m, out_valid);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    test_reset();
    test_back_to_back();
    test_zero_inf();
    test_ovf_unf_nan();
    test_rounding();
    test_valid_gating();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_f32_pipe.md
Name: mult_f32_pipe

Overview:
- Single-precision (IEEE-754 binary32) floating-point multiplier used by the processing element datapath.
- Takes two 32-bit operands and produces their product one clock later through a registered output stage.
- Simplified special-value rules: subnormals flush to zero, and infinity dominates zero.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b are valid this cycle
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- out_valid  output  1  m holds the product of the operands presented with in_valid one cycle earlier
- m  output  32  product, binary32

Behaviour:
- Reset: rst=1 at a rising edge sets m=32'h00000000 and out_valid=0. Reset mid-operation discards the in-flight result.
- Latency: exactly 1 cycle. Operands are sampled at edge N when in_valid=1; m and out_valid=1 appear after edge N. Fully pipelined, so a new operand pair is accepted every cycle.
- in_valid=0 at an edge: out_valid goes to 0 and m holds its previous value.
- Field decode: sign s=bit31, exponent e=bits30:23, fraction f=bits22:0.
- Input classes: zero when e=0 (any f, so subnormals are treated as zero); infinity when e=255, f=0; NaN when e=255, f!=0; otherwise normal with significand {1,f}.
- Result sign is always sa XOR sb, except for NaN results.
- Special cases, applied in priority order:
  - Either input NaN: m=32'h7FC00000.
  - Either input infinity (including inf*0): m={s,8'hFF,23'h0}.
  - Either input zero: m={s,31'h0}.
- Normal path:
  - Form the 24x24 significand product (48 bits).
  - If bit47 is set, normalize right by 1 and increment the exponent.
  - Exponent = ea + eb - 127 (+1 if normalized), computed in at least 10-bit signed arithmetic.
  - Round to nearest, ties to even, using guard, round and sticky bits.
  - A rounding carry-out renormalizes (exponent+1).
- Overflow: final biased exponent >= 255 gives m={s,8'hFF,23'h0}.
- Underflow: final biased exponent <= 0 gives m={s,31'h0} (flush to zero; no subnormal outputs).
- No exception flags are generated.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=32'h40200000 -> m=32'h00000000, out_valid=0. Release rst -> result appears 1 cycle later.
- Normal products, one per cycle, back-to-back. Each result appears exactly one cycle after its operands:
  - 32'h40200000*32'h40400000 (2.5*3.0) -> 32'h40F00000.
  - 32'hBF8CCCCD*32'h40A00000 (-1.1*5.0) -> 32'hC0B00000.
  - 32'h3F800000*32'h3F800000 -> 32'h3F800000.
- Zero and infinity:
  - 32'h40400000*32'h00000000 -> 32'h00000000.
  - 32'h7F800000*32'h00000000 -> 32'h7F800000.
  - 32'h00000000*32'h7F800000 -> 32'h7F800000.
  - 32'hBF800000*32'h7F800000 -> 32'hFF800000.
  - 32'h3F800000*32'hFF800000 -> 32'hFF800000.
  - 32'hBF800000*32'hFF800000 -> 32'h7F800000.
- Overflow, underflow and NaN:
  - 32'h7F000000*32'h40000000 -> 32'h7F800000.
  - 32'h00800000*32'h00800000 -> 32'h00000000.
  - 32'h7FC00001*32'h3F800000 -> 32'h7FC00000.
- Rounding and valid gating:
  - Compare 32'h3F4F245A*32'h3F34C34A and 32'h49742400*32'h4CEAD734 bit-exactly against a round-to-nearest-even reference model.
  - Drop in_valid for one cycle mid-stream -> out_valid=0 for that cycle and m held.
